// File: rtl/counter_stepper.sv
// counter_stepper
// ---------------
// Command-side driver for a WIDTH-bit wrapping up/down counter. A target value
// is accepted through a ready/start handshake; the block then emits a paced
// train of one-cycle increase/decrease pulses (one every STEP_DIV cycles)
// until a shadow copy of the downstream count reaches the target, and then
// pulses done. rst must reach the downstream counter on the same edge, so
// shadow=0 matches the counter's power-up value.
//
// Parameters:
//   WIDTH     counter width, must match the downstream counter
//   STEP_DIV  clock cycles between step pulses, 1..255
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     move request, accepted only while ready=1
//   target    destination value, sampled on an accepted start
//   ready     high while a new request can be accepted
//   increase  one-cycle step-up pulse to the counter
//   decrease  one-cycle step-down pulse to the counter
//   shadow    modelled counter value (leads the counter by one cycle)
//   done      one-cycle pulse when the move is complete
//
// Build option:
//   COUNTER_STEPPER_SHORTEST_PATH_EN  when defined, moves take the shortest
//   modular path (half-way tie goes up); otherwise an unsigned compare is used
//   and the path never wraps.

module counter_stepper #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  output logic             ready,
  output logic             increase,
  output logic             decrease,
  output logic [WIDTH-1:0] shadow,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0]       DIV_LAST = 8'(STEP_DIV - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state;
  logic [7:0]       divider;
  logic [WIDTH-1:0] remaining;
  logic             dir_up;

  // Direction and distance for a request issued against the current shadow.
  logic             plan_up;
  logic [WIDTH-1:0] plan_dist;

`ifdef COUNTER_STEPPER_SHORTEST_PATH_EN
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] up_dist;

  always_comb begin
    up_dist   = target - shadow;
    plan_up   = 1'b1;
    plan_dist = up_dist;
    if (up_dist > HALF) begin
      // 2^WIDTH - up is the same bit pattern as shadow - target.
      plan_up   = 1'b0;
      plan_dist = shadow - target;
    end
  end
`else
  always_comb begin
    plan_up   = 1'b1;
    plan_dist = target - shadow;
    if (target < shadow) begin
      plan_up   = 1'b0;
      plan_dist = shadow - target;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      increase  <= 1'b0;
      decrease  <= 1'b0;
      done      <= 1'b0;
      shadow    <= '0;
      divider   <= '0;
      remaining <= '0;
      dir_up    <= 1'b1;
    end else begin
      increase <= 1'b0;
      decrease <= 1'b0;
      done     <= 1'b0;

      unique case (state)
        S_IDLE: begin
          // IDLE with ready low is the cycle in which done is high; ready
          // comes back at the edge that ends it.
          if (!ready) begin
            ready <= 1'b1;
          end else if (start) begin
            ready     <= 1'b0;
            dir_up    <= plan_up;
            remaining <= plan_dist;
            divider   <= '0;
            state     <= (plan_dist == '0) ? S_DONE : S_RUN;
          end
        end

        S_RUN: begin
          if (divider == DIV_LAST) begin
            divider   <= '0;
            remaining <= remaining - ONE;
            if (dir_up) begin
              increase <= 1'b1;
              shadow   <= shadow + ONE;
            end else begin
              decrease <= 1'b1;
              shadow   <= shadow - ONE;
            end
            if (remaining == ONE) begin
              state <= S_DONE;
            end
          end else begin
            divider <= divider + 8'd1;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_stepper.sv
module tb_counter_stepper;

  localparam int KIND_INC  = 0;
  localparam int KIND_DEC  = 1;
  localparam int KIND_DONE = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] sh;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, start1 = 1'b0;
  logic [15:0] target4 = '0, target1 = '0;
  logic        ready4, increase4, decrease4, done4;
  logic        ready1, increase1, decrease1, done1;
  logic [15:0] shadow4, shadow1;
  logic [15:0] cnt4, cnt1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  exp_t        q4[$];
  exp_t        q1[$];
  logic [15:0] msh[2];
  bit          pend[2];
  logic [15:0] pval[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_stepper #(.WIDTH(16), .STEP_DIV(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .target(target4), .ready(ready4),
    .increase(increase4), .decrease(decrease4), .shadow(shadow4), .done(done4)
  );

  counter_stepper #(.WIDTH(16), .STEP_DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .target(target1), .ready(ready1),
    .increase(increase1), .decrease(decrease1), .shadow(shadow1), .done(done1)
  );

  // Downstream wrapping up/down counters driven by the two steppers.
  always @(posedge clk) begin
    if (rst) cnt4 <= '0;
    else if (increase4) cnt4 <= cnt4 + 16'd1;
    else if (decrease4) cnt4 <= cnt4 - 16'd1;
  end
  always @(posedge clk) begin
    if (rst) cnt1 <= '0;
    else if (increase1) cnt1 <= cnt1 + 16'd1;
    else if (decrease1) cnt1 <= cnt1 - 16'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q4.size() : q1.size();
  endfunction

  task automatic mon_one(input int sel, input logic inc, input logic dec,
                         input logic dn, input logic rdy,
                         input logic [15:0] sh, input logic [15:0] cnt);
    exp_t e;
    int   ak;
    if (pend[sel]) begin
      chk($sformatf("cnt_follows_shadow%0d", sel), int'(cnt), int'(pval[sel]));
      pend[sel] = 1'b0;
    end
    if (inc || dec || dn) begin
      if (inc || dec) chk($sformatf("inc_dec_exclusive%0d", sel), int'(inc & dec), 0);
      if (qsize(sel) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output%0d (cycle %0d): got inc=%0b dec=%0b done=%0b expected none",
                 sel, cyc, inc, dec, dn);
      end else begin
        e  = (sel == 0) ? q4.pop_front() : q1.pop_front();
        ak = dn ? KIND_DONE : (dec ? KIND_DEC : KIND_INC);
        chk($sformatf("out_kind%0d", sel), ak, e.kind);
        chk($sformatf("out_cycle%0d", sel), cyc, e.cyc);
        chk($sformatf("out_shadow%0d", sel), int'(sh), int'(e.sh));
        if (dn) begin
          chk($sformatf("ready_low_in_done%0d", sel), int'(rdy), 0);
          chk($sformatf("cnt_at_done%0d", sel), int'(cnt), int'(e.sh));
        end else begin
          pend[sel] = 1'b1;
          pval[sel] = e.sh;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_one(0, increase4, decrease4, done4, ready4, shadow4, cnt4);
      mon_one(1, increase1, decrease1, done1, ready1, shadow1, cnt1);
    end
  end

  task automatic check_reset_state();
    chk("rst_ready", int'(ready4), 1);
    chk("rst_increase", int'(increase4), 0);
    chk("rst_decrease", int'(decrease4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_shadow", int'(shadow4), 0);
    chk("rst_cnt", int'(cnt4), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    msh[0] = '0; msh[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
  endtask

  // Issue one move: hand-derived direction (up) and distance (n). When
  // npush < n, only the first npush pulses are expected and rst is applied
  // right after the last of them; no further pulses may follow.
  task automatic move(input int sel, input logic [15:0] tgt, input bit up,
                      input int n, input int npush, input bit glitch);
    int   sd, e0, np;
    exp_t e;
    sd = (sel == 0) ? 4 : 1;
    for (int i = 0; i < 50 && !((sel == 0) ? ready4 : ready1); i++) @(negedge clk);
    chk($sformatf("ready_before_start%0d", sel), int'((sel == 0) ? ready4 : ready1), 1);
    e0 = cyc + 1;
    np = (npush < n) ? npush : n;
    for (int k = 1; k <= np; k++) begin
      msh[sel] = up ? msh[sel] + 16'd1 : msh[sel] - 16'd1;
      e.kind = up ? KIND_INC : KIND_DEC;
      e.cyc  = e0 + k * sd;
      e.sh   = msh[sel];
      if (sel == 0) q4.push_back(e); else q1.push_back(e);
    end
    if (npush >= n) begin
      e.kind = KIND_DONE;
      e.cyc  = e0 + n * sd + 1;
      e.sh   = msh[sel];
      if (sel == 0) q4.push_back(e); else q1.push_back(e);
    end
    if (sel == 0) begin start4 = 1'b1; target4 = tgt; end
    else          begin start1 = 1'b1; target1 = tgt; end
    @(negedge clk);
    // Deassert start and disturb target; neither may affect the move.
    if (sel == 0) begin start4 = 1'b0; target4 = 16'hDEAD; end
    else          begin start1 = 1'b0; target1 = 16'hDEAD; end
    if (glitch) begin
      repeat (5) @(negedge clk);
      start4 = 1'b1; target4 = 16'h1234;
      @(negedge clk);
      start4 = 1'b0;
    end
    if (npush < n) begin
      for (int i = 0; i < n * sd + 20 && cyc < e0 + npush * sd + 1; i++) @(negedge clk);
      do_reset();
      repeat (12) @(negedge clk);
    end else begin
      for (int i = 0; i < n * sd + 20 && qsize(sel) != 0; i++) @(negedge clk);
    end
    chk($sformatf("queue_drained%0d", sel), qsize(sel), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    msh[0] = '0; msh[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    move(0, 16'h0005, 1'b1, 5, 5, 1'b0);   // 5 up pulses, shadow 1..5
    move(0, 16'h0002, 1'b0, 3, 3, 1'b1);   // 3 down pulses, start glitch ignored
    move(0, 16'h0002, 1'b1, 0, 0, 1'b0);   // zero distance: done only
    move(0, 16'h0000, 1'b0, 2, 2, 1'b0);   // 2 -> 0 down
`ifdef COUNTER_STEPPER_SHORTEST_PATH_EN
    move(0, 16'hFFFE, 1'b0, 2, 2, 1'b0);   // wraps down: FFFF, FFFE
    do_reset();
`else
    move(0, 16'hFFFE, 1'b1, 16'hFFFE, 3, 1'b0);  // counts 1,2,3 then reset
`endif
    move(0, 16'h8000, 1'b1, 32768, 2, 1'b0);     // half-way tie goes up
    move(0, 16'h0005, 1'b1, 5, 2, 1'b0);         // reset after 2 of 5 pulses
    move(1, 16'h0003, 1'b1, 3, 3, 1'b0);         // STEP_DIV=1, back-to-back

    chk("final_q4_empty", q4.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
